// File: rtl/cache_array_mp_if.sv
// rtl/cache_array_mp_if.sv - controller-side bus of cache_array_mp (optional CACHE_ARRAY_PARITY_EN adds parity_err)
interface cache_array_mp_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_RD = 2
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = WIDTH / 8;

    logic                      load;
    logic [IDX_W-1:0]          windex;
    logic [NB-1:0]             wmask;
    logic [WIDTH-1:0]          datain;
    logic                      inv;
    logic [IDX_W-1:0]          inv_index;
    logic                      flush_req;
    logic                      flush_busy;
    logic [NUM_RD*IDX_W-1:0]   rindex;
    logic [NUM_RD*WIDTH-1:0]   dataout;
    logic [NUM_RD-1:0]         valid_out;
`ifdef CACHE_ARRAY_PARITY_EN
    logic [NUM_RD-1:0]         parity_err;

    modport master (
        output load, windex, wmask, datain, inv, inv_index, flush_req, rindex,
        input  flush_busy, dataout, valid_out, parity_err
    );
    modport slave (
        input  load, windex, wmask, datain, inv, inv_index, flush_req, rindex,
        output flush_busy, dataout, valid_out, parity_err
    );
`else
    modport master (
        output load, windex, wmask, datain, inv, inv_index, flush_req, rindex,
        input  flush_busy, dataout, valid_out
    );
    modport slave (
        input  load, windex, wmask, datain, inv, inv_index, flush_req, rindex,
        output flush_busy, dataout, valid_out
    );
`endif
endinterface

// File: rtl/cache_array_mp.sv
// rtl/cache_array_mp.sv - multi-read-port cache array with valid bits, masked writes, invalidate and flush sweep
// Optional byte parity checking is enabled by defining CACHE_ARRAY_PARITY_EN.
module cache_array_mp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_RD = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_array_mp_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = WIDTH / 8;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        ptr, ptr_nxt;
    logic [WIDTH-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]        valid;
    logic [WIDTH-1:0]        wbits;
    logic                    busy;
    logic                    wr_en;
    logic [NUM_RD*WIDTH-1:0] dout;
    logic [NUM_RD-1:0]       vout;
`ifdef CACHE_ARRAY_PARITY_EN
    logic [NB-1:0]           par [DEPTH];
    logic [NUM_RD-1:0]       perr;
`endif

    assign busy           = (state == FLUSH);
    assign wr_en          = bus.load && !busy;
    assign bus.flush_busy = busy;
    assign bus.dataout    = dout;
    assign bus.valid_out  = vout;

    // Byte enables expanded to bit enables, shared by the write path and every bypass.
    always_comb begin
        wbits = '0;
        for (int b = 0; b < NB; b++)
            wbits[8*b +: 8] = {8{bus.wmask[b]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (bus.flush_req) begin
                    state_nxt = FLUSH;
                    ptr_nxt   = '0;
                end
            end
            FLUSH: begin
                ptr_nxt = ptr + IDX_W'(1);
                if (ptr == IDX_W'(DEPTH - 1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
`ifdef CACHE_ARRAY_PARITY_EN
                par[i] <= '0;
`endif
            end
            valid <= '0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.wmask[b]) begin
                        mem[bus.windex][8*b +: 8] <= bus.datain[8*b +: 8];
`ifdef CACHE_ARRAY_PARITY_EN
                        par[bus.windex][b] <= ^bus.datain[8*b +: 8];
`endif
                    end
                end
            end
            // Load is ordered after invalidate so a same-index collision leaves the entry valid.
            if (busy) begin
                valid[ptr] <= 1'b0;
            end else begin
                if (bus.inv)
                    valid[bus.inv_index] <= 1'b0;
                if (wr_en)
                    valid[bus.windex] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] stored;
        logic             hit_wr;
        logic             hit_inv;

        assign idx     = bus.rindex[p*IDX_W +: IDX_W];
        assign stored  = mem[idx];
        assign hit_wr  = wr_en && (bus.windex == idx);
        assign hit_inv = bus.inv && (bus.inv_index == idx);

        assign dout[p*WIDTH +: WIDTH] = hit_wr ? ((bus.datain & wbits) | (stored & ~wbits)) : stored;
        assign vout[p] = !busy && (hit_wr || (!hit_inv && valid[idx]));

`ifdef CACHE_ARRAY_PARITY_EN
        logic [NB-1:0] pcalc;
        always_comb begin
            pcalc = '0;
            for (int b = 0; b < NB; b++)
                pcalc[b] = ^stored[8*b +: 8];
        end
        assign perr[p] = !busy && !hit_wr && !hit_inv && valid[idx] && (pcalc != par[idx]);
`endif
    end

`ifdef CACHE_ARRAY_PARITY_EN
    assign bus.parity_err = perr;
`endif
endmodule

// File: doc/cache_array_mp.md
Name: cache_array_mp

Overview:
- Parametrised multi-read-port storage array for cache tag, data and metadata, replacing the fixed 8-entry single-port array.
- Adds:
  - per-entry valid bits
  - byte-masked writes with masked write-through bypass
  - single-entry invalidate
  - a sequential flush engine that clears all valid bits, one entry per cycle
- Sits beside each cache way; the cache controller drives it.

Parameters:
- WIDTH, 32, data bits per entry; must be a multiple of 8.
- DEPTH, 8, number of entries; power of 2, >= 2.
- NUM_RD, 2, number of independent combinational read ports, >= 1.
- Derived localparams: IDX_W = $clog2(DEPTH); NB = WIDTH/8.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  write strobe.
- windex  in  IDX_W  write index.
- wmask  in  NB  byte enables for the write; bit b covers datain[8b+7:8b].
- datain  in  WIDTH  write data.
- inv  in  1  invalidate strobe for one entry.
- inv_index  in  IDX_W  index to invalidate.
- flush_req  in  1  single-cycle request to invalidate all entries.
- flush_busy  out  1  high while the flush sweep runs.
- rindex  in  NUM_RD*IDX_W  read index; port p uses slice [p*IDX_W +: IDX_W].
- dataout  out  NUM_RD*WIDTH  read data; port p uses slice [p*WIDTH +: WIDTH].
- valid_out  out  NUM_RD  valid bit per read port.

Behaviour:
- Reset (async assert, sync-free deassert):
  - all data entries = 0, all valid = 0
  - FSM = IDLE, flush pointer = 0, flush_busy = 0
  - dataout and valid_out then read 0.
- Write:
  - When load && !flush_busy: bytes with wmask[b]=1 are written at windex on the clock edge; unmasked bytes are kept.
  - valid[windex] <= 1, even when wmask = 0.
- Read (per port p, combinational, zero latency):
  - Default: dataout_p = data[rindex_p]; valid_out_p = valid[rindex_p].
  - Bypass: if load && !flush_busy && windex == rindex_p, then dataout_p = masked merge (datain on enabled bytes, stored bytes elsewhere) and valid_out_p = 1.
  - Invalidate bypass: else if inv && inv_index == rindex_p, then valid_out_p = 0 and dataout_p is the stored data.
  - All ports are evaluated independently; several ports may read the same index.
- Invalidate:
  - When inv && !flush_busy: valid[inv_index] <= 0; data is unchanged.
  - load and inv to the same index in the same cycle: load wins, valid = 1.
  - Different indices: both take effect.
- Flush FSM, states IDLE and FLUSH:
  - IDLE -> FLUSH on flush_req. Pointer = 0. flush_busy goes high the cycle after the request.
  - In FLUSH: each cycle valid[ptr] <= 0 and ptr increments.
  - FLUSH -> IDLE after the cycle with ptr == DEPTH-1, so flush_busy is high for exactly DEPTH cycles. The pointer wraps to 0.
  - A flush_req in the same cycle as load/inv: the load/inv is applied in that cycle, and the flush then clears it.
  - While flush_busy: load, inv and flush_req are ignored (the controller must hold them), valid_out is forced to 0 on all ports, and dataout shows stored data.
  - rst_n asserted mid-flush: immediate return to IDLE with everything cleared.

Optional Feature:
- Macro: CACHE_ARRAY_PARITY_EN.
- Defined:
  - Adds port parity_err  out  NUM_RD.
  - Stores one even-parity bit per byte, updated only for written bytes. Parity is reset to 0, which is consistent with zero data.
  - parity_err_p = 1 when the stored entry at rindex_p has any byte parity mismatch, valid[rindex_p] = 1 and the read is not bypassed. Otherwise 0.
  - Forced to 0 while flush_busy.
- Undefined:
  - No parity_err port and no parity storage.
  - Behaviour is otherwise identical.

Test Plan:
- Reset then read every index on all ports -> dataout = 0, valid_out = 0, flush_busy = 0.
- load=1, windex=3, wmask=4'b1111, datain=32'hDEADBEEF, rindex0=3 in the same cycle -> dataout0 = DEADBEEF, valid_out0 = 1 in that cycle. Next cycle, with load=0 and rindex0=rindex1=3, both ports read DEADBEEF with valid = 1.
- Entry 3 = DEADBEEF; write wmask=4'b0101, datain=32'h11223344 -> the bypass read and the next-cycle read both give DE22BE44.
- Same cycle: load at index 5 and inv at index 5 -> valid[5] = 1 next cycle. Separately, inv at index 2 with rindex1=2 -> valid_out1 = 0 in that cycle.
- Fill all 8 entries, pulse flush_req:
  - flush_busy is high for 8 cycles; a load issued during the flush is not applied.
  - Afterwards all valid = 0 and the data is retained.
  - Repeat with rst_n asserted at flush cycle 4 -> IDLE, all cleared.
- Parity (CACHE_ARRAY_PARITY_EN): write AA at index 1, force one stored data bit to flip -> parity_err0 = 1 when rindex0 = 1. The same read during a bypassing write -> 0.
